mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
//
// Sequential front-end for a 4:1 mux stage. It steps the mux select through
// the enabled channels and holds each channel for DWELL cycles so the mux
// output can settle. On the last cycle of each dwell it samples y_in into a
// capture register. When the last enabled channel has been sampled, it presents
// the assembled 4-bit word downstream with a valid/ready handshake.
// Single-sweep and continuous modes are supported.
//
// Ports:
//   clk_in      - clock, rising edge
//   rst_n_in    - asynchronous active-low reset
//   start_in    - request a sweep (only looked at in IDLE)
//   mode_in     - 0 = single sweep, 1 = continuous (sampled at each handshake)
//   ch_mask_in  - channel enable mask, snapshotted when start is accepted
//   y_in        - output of the 4:1 mux being scanned
//   sel_out     - registered mux select
//   sample_out  - completed sweep word, bit n = channel n (disabled -> 0)
//   valid_out   - sample_out holds a completed sweep
//   ready_in    - consumer accepts sample_out
//   busy_out    - high whenever the sequencer is not idle
//   done_out    - one-cycle pulse when the sequencer returns to IDLE
// -----------------------------------------------------------------------------
module mux_scan_sequencer #(
    parameter int DWELL = 4,   // cycles per channel, 2..255
    parameter int CNT_W = 8    // must hold DWELL-1
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       start_in,
    input  logic       mode_in,
    input  logic [3:0] ch_mask_in,
    input  logic       y_in,
    output logic [1:0] sel_out,
    output logic [3:0] sample_out,
    output logic       valid_out,
    input  logic       ready_in,
    output logic       busy_out,
    output logic       done_out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DWELL   = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    state_t             state_reg,  state_next;
    logic [1:0]         sel_reg,    sel_next;
    logic [3:0]         sample_reg, sample_next;
    logic               valid_reg,  valid_next;
    logic               done_reg,   done_next;
    logic [CNT_W-1:0]   count_reg,  count_next;
    logic [3:0]         mask_reg,   mask_next;
    logic [3:0]         cap_reg,    cap_next;

    // Enabled channels strictly above the one currently selected.
    logic [3:0]         above_sel;
    logic               dwell_end;
    logic [3:0]         cap_with_sample;

    // Lowest set bit of a 4-bit vector (returns 3 for an empty vector; callers
    // only use it on non-empty vectors).
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] r;
        if (v[0])      r = 2'd0;
        else if (v[1]) r = 2'd1;
        else if (v[2]) r = 2'd2;
        else           r = 2'd3;
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_above
            assign above_sel[gi] = mask_reg[gi] && (sel_reg < 2'(gi));
        end
    endgenerate

    assign dwell_end = (count_reg == CNT_W'(DWELL - 1));

    // Capture register as it will look after this edge's sample, so the final
    // channel's sample lands in sample_out on the same edge.
    always_comb begin
        cap_with_sample          = cap_reg;
        cap_with_sample[sel_reg] = y_in;
    end

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        sample_next = sample_reg;
        valid_next  = valid_reg;
        done_next   = 1'b0;
        count_next  = count_reg;
        mask_next   = mask_reg;
        cap_next    = cap_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start_in) begin
                    if (|ch_mask_in) begin
                        mask_next  = ch_mask_in;
                        cap_next   = 4'b0000;
                        sel_next   = lowest_set(ch_mask_in);
                        count_next = '0;
                        state_next = ST_DWELL;
                    end else begin
                        // Nothing to scan: report completion without data.
                        done_next = 1'b1;
                    end
                end
            end

            ST_DWELL: begin
                count_next = count_reg + CNT_W'(1);
                if (dwell_end) begin
                    cap_next   = cap_with_sample;
                    count_next = '0;
                    if (|above_sel) begin
                        sel_next = lowest_set(above_sel);
                    end else begin
                        sample_next = cap_with_sample;
                        valid_next  = 1'b1;
                        state_next  = ST_PRESENT;
                    end
                end
            end

            ST_PRESENT: begin
                // valid_reg is always set in this state, so ready alone
                // completes the handshake.
                if (ready_in) begin
                    valid_next = 1'b0;
                    if (mode_in) begin
                        cap_next   = 4'b0000;
                        sel_next   = lowest_set(mask_reg);
                        count_next = '0;
                        state_next = ST_DWELL;
                    end else begin
                        done_next  = 1'b1;
                        sel_next   = 2'b00;
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                sel_next   = 2'b00;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg  <= ST_IDLE;
            sel_reg    <= 2'b00;
            sample_reg <= 4'b0000;
            valid_reg  <= 1'b0;
            done_reg   <= 1'b0;
            count_reg  <= '0;
            mask_reg   <= 4'b0000;
            cap_reg    <= 4'b0000;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            sample_reg <= sample_next;
            valid_reg  <= valid_next;
            done_reg   <= done_next;
            count_reg  <= count_next;
            mask_reg   <= mask_next;
            cap_reg    <= cap_next;
        end
    end

    assign sel_out    = sel_reg;
    assign sample_out = sample_reg;
    assign valid_out  = valid_reg;
    assign done_out   = done_reg;
    assign busy_out   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for mux_scan_sequencer. A behavioural model derives, for each
// sweep, the list of visited channels, their dwell windows, the expected word
// (data & mask) and the handshake/done behaviour, and compares the DUT
// cycle by cycle. Directed scenarios are followed by randomized sweeps.
// -----------------------------------------------------------------------------
module tb_mux_scan_sequencer;

    localparam int DWELL = 4;
    localparam int CNT_W = 8;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       start_in;
    logic       mode_in;
    logic [3:0] ch_mask_in;
    logic       y_in;
    logic [1:0] sel_out;
    logic [3:0] sample_out;
    logic       valid_out;
    logic       ready_in;
    logic       busy_out;
    logic       done_out;

    logic [3:0] mux_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    // The scanned 4:1 mux.
    assign y_in = mux_data[sel_out];

    mux_scan_sequencer #(.DWELL(DWELL), .CNT_W(CNT_W)) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .start_in   (start_in),
        .mode_in    (mode_in),
        .ch_mask_in (ch_mask_in),
        .y_in       (y_in),
        .sel_out    (sel_out),
        .sample_out (sample_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .busy_out   (busy_out),
        .done_out   (done_out)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int lowest_ch(input logic [3:0] m);
        int r;
        r = -1;
        for (int c = 3; c >= 0; c--) if (m[c]) r = c;
        return r;
    endfunction

    // Issue a start with the given mask; on return we are just after the
    // accepting edge.
    task automatic start_sweep(input logic [3:0] mask);
        ch_mask_in = mask;
        start_in   = 1'b1;
        tick();
        start_in   = 1'b0;
        if (mask != 4'b0000) begin
            check_val("start_busy", 32'(busy_out), 32'd1);
            check_val("start_sel", 32'(sel_out), 32'(lowest_ch(mask)));
        end else begin
            check_val("empty_done", 32'(done_out), 32'd1);
            check_val("empty_valid", 32'(valid_out), 32'd0);
            check_val("empty_busy", 32'(busy_out), 32'd0);
            tick();
            check_val("empty_done_clr", 32'(done_out), 32'd0);
            check_val("empty_valid2", 32'(valid_out), 32'd0);
            $display("sweep mask=%b : empty, done only", mask);
        end
    endtask

    // One sweep from the cycle right after it began (start accept or
    // continuous handshake) through its own handshake.
    task automatic run_body(input logic [3:0] mask, input logic [3:0] data,
                            input logic mode_val, input int stall);
        logic [3:0] exp_word;
        int         chans[$];
        int         last_ch;
        int         cycles;
        exp_word = data & mask;
        mux_data = data;
        for (int c = 0; c < 4; c++) if (mask[c]) chans.push_back(c);
        last_ch = chans[chans.size() - 1];
        cycles  = 0;

        foreach (chans[i]) begin
            for (int j = 0; j < DWELL; j++) begin
                check_val("dwell_sel", 32'(sel_out), 32'(chans[i]));
                check_val("dwell_valid", 32'(valid_out), 32'd0);
                check_val("dwell_busy", 32'(busy_out), 32'd1);
                // Noise that must be ignored mid-sweep.
                ready_in   = 1'($urandom_range(0, 1));
                start_in   = 1'($urandom_range(0, 1));
                mode_in    = 1'($urandom_range(0, 1));
                ch_mask_in = 4'($urandom_range(0, 15));
                tick();
                cycles++;
            end
        end
        check_val("latency", 32'(cycles), 32'(chans.size() * DWELL));
        check_val("word_valid", 32'(valid_out), 32'd1);
        check_val("word_sample", 32'(sample_out), 32'(exp_word));
        check_val("word_done", 32'(done_out), 32'd0);

        for (int s = 0; s < stall; s++) begin
            ready_in = 1'b0;
            start_in = 1'($urandom_range(0, 1));
            tick();
            check_val("hold_valid", 32'(valid_out), 32'd1);
            check_val("hold_sample", 32'(sample_out), 32'(exp_word));
            check_val("hold_sel", 32'(sel_out), 32'(last_ch));
        end

        start_in = 1'b0;
        mode_in  = mode_val;
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        check_val("hs_valid", 32'(valid_out), 32'd0);
        check_val("hs_sample_kept", 32'(sample_out), 32'(exp_word));
        if (!mode_val) begin
            check_val("hs_done", 32'(done_out), 32'd1);
            check_val("hs_sel_home", 32'(sel_out), 32'd0);
            check_val("hs_idle", 32'(busy_out), 32'd0);
            tick();
            check_val("done_pulse_clr", 32'(done_out), 32'd0);
            check_val("idle_sample_kept", 32'(sample_out), 32'(exp_word));
        end else begin
            check_val("cont_no_done", 32'(done_out), 32'd0);
            check_val("cont_busy", 32'(busy_out), 32'd1);
            check_val("cont_sel", 32'(sel_out), 32'(chans[0]));
        end
        $display("sweep mask=%b data=%b mode=%0d stall=%0d -> sample=%b (exp %b) after %0d cycles",
                 mask, data, mode_val, stall, sample_out, exp_word, cycles);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_sel"}, 32'(sel_out), 32'd0);
        check_val({tag, "_sample"}, 32'(sample_out), 32'd0);
        check_val({tag, "_valid"}, 32'(valid_out), 32'd0);
        check_val({tag, "_busy"}, 32'(busy_out), 32'd0);
        check_val({tag, "_done"}, 32'(done_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] m;
        int         chain;

        // Reset held with start asserted.
        rst_n_in   = 1'b0;
        start_in   = 1'b1;
        mode_in    = 1'b0;
        ch_mask_in = 4'b1111;
        ready_in   = 1'b0;
        mux_data   = 4'b0000;
        repeat (3) @(posedge clk_in);
        #1;
        check_reset_values("reset");
        start_in = 1'b0;
        rst_n_in = 1'b1;
        tick();
        check_reset_values("post_reset");

        // Full sweep, single mode.
        start_sweep(4'b1111);
        run_body(4'b1111, 4'b1101, 1'b0, 0);

        // Sparse mask.
        start_sweep(4'b0101);
        run_body(4'b0101, 4'b1111, 1'b0, 0);

        // Backpressure for 10 cycles.
        start_sweep(4'b1011);
        run_body(4'b1011, 4'b0110, 1'b0, 10);

        // Continuous mode, data changes between sweeps, then drop mode.
        start_sweep(4'b1010);
        run_body(4'b1010, 4'b1010, 1'b1, 0);
        run_body(4'b1010, 4'b0010, 1'b0, 0);

        // Empty mask.
        start_sweep(4'b0000);

        // Asynchronous reset during the channel-2 dwell.
        mux_data = 4'b1111;
        start_sweep(4'b1111);
        repeat (2 * DWELL + 1) tick();
        check_val("mid_sel_ch2", 32'(sel_out), 32'd2);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_reset_values("async_reset");
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();
        check_reset_values("after_async");
        start_sweep(4'b0110);
        run_body(4'b0110, 4'b0101, 1'b0, 1);

        // Randomized sweeps, including continuous chains.
        for (int it = 0; it < 25; it++) begin
            m = 4'($urandom_range(0, 15));
            start_sweep(m);
            if (m != 4'b0000) begin
                chain = $urandom_range(1, 3);
                for (int k = 0; k < chain; k++) begin
                    run_body(m, 4'($urandom_range(0, 15)), 1'(k < chain - 1),
                             $urandom_range(0, 4));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
